wt32_seq_ctrl: RTL

- Sequencing controller that computes a 32x32 unsigned product by time-sharing one external 16x16 radix-4 multiplier across the four half-word partial products (LL, HL, LH, HH).
- Accumulates the shifted partial products into a 64-bit result.
- Selects approximate or accurate mode per partial product.
- Sits between a requester using valid/ready handshakes and a shared radix-4 multiplier slice. This replaces four parallel multiplier instances where area matters.

---
 rtl/wt32_seq_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wt32_seq_ctrl.sv
// Sequencing controller that forms a 2N-bit product by running four K x K partial
// products through one shared external multiplier and accumulating the shifted results.
module wt32_seq_ctrl #(
    parameter int         N           = 32,
    parameter logic [3:0] APPROX_MASK = 4'b0111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic [N/2-1:0]   mul_x,
    output logic [N/2-1:0]   mul_y,
    output logic             mul_approx,
    input  logic [N-1:0]     mul_p,
    output logic [2:0]       dbg_state
);
    localparam int K = N / 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LL   = 3'd1,
        HL   = 3'd2,
        LH   = 3'd3,
        HH   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [3:0]       mode_q;
    logic [2*N-1:0]   acc_q;
    logic [2*N-1:0]   pp_ext;
    logic [2*N-1:0]   pp_shift;
    logic             accept;
    logic             compute;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the source holds valid and payload stable until that edge, ready never waits on valid.
    assign accept    = in_valid && in_ready;
    assign pp_ext    = {{N{1'b0}}, mul_p};
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
            acc_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                mode_q <= in_exact ? 4'b0000 : APPROX_MASK;
                acc_q  <= '0;
            end else if (compute) begin
                acc_q <= acc_q + pp_shift;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_p      = '0;
        mul_x      = '0;
        mul_y      = '0;
        mul_approx = 1'b0;
        compute    = 1'b0;
        pp_shift   = pp_ext;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LL;
            end
            LL: begin
                mul_x      = a_q[K-1:0];
                mul_y      = b_q[K-1:0];
                mul_approx = mode_q[0];
                compute    = 1'b1;
                state_nxt  = HL;
            end
            HL: begin
                mul_x      = a_q[N-1:K];
                mul_y      = b_q[K-1:0];
                mul_approx = mode_q[1];
                compute    = 1'b1;
                pp_shift   = pp_ext << K;
                state_nxt  = LH;
            end
            LH: begin
                mul_x      = a_q[K-1:0];
                mul_y      = b_q[N-1:K];
                mul_approx = mode_q[2];
                compute    = 1'b1;
                pp_shift   = pp_ext << K;
                state_nxt  = HH;
            end
            HH: begin
                mul_x      = a_q[N-1:K];
                mul_y      = b_q[N-1:K];
                mul_approx = mode_q[3];
                compute    = 1'b1;
                pp_shift   = pp_ext << (2 * K);
                state_nxt  = DONE;
            end
            DONE: begin
                // Result is held until the consumer takes it; no new request overlaps.
                out_valid = 1'b1;
                out_p     = acc_q;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
